// File: rtl/cla_nibble_serial_add_ctrl.sv
// Nibble-serial wide adder: one shared 4-bit carry-lookahead adder is stepped
// across the operand LSB nibble first, with the carry chained through a
// register between nibbles. Operands and results move through valid/ready
// handshakes.

// 4-bit carry-lookahead adder, purely combinational.
module carry_lookahead_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] S,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        S    = p ^ c;
    end

endmodule

module cla_nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx;

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [3:0]        nib_s;
    logic              nib_c;
    logic [WIDTH-1:0]  sum_fin;
    logic              ovf_fin;

    carry_lookahead_adder u_cla (
        .A    (nib_a),
        .B    (nib_b),
        .cin  (carry_q),
        .S    (nib_s),
        .cout (nib_c)
    );

    // Select the current nibble of each operand and form the full result as it
    // will look once the top nibble lands, so DONE outputs load in one step.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIB; n++) begin
            if (idx == IDXW'(n)) begin
                nib_a = a_q[4*n +: 4];
                nib_b = b_q[4*n +: 4];
            end
        end
        sum_fin                = sum_q;
        sum_fin[WIDTH-1 -: 4]  = nib_s;
        ovf_fin = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
    end

    // Sequencer: accept operands, step one nibble per clock, then hold the
    // result until the consumer takes it. Result outputs are separate
    // registers so they keep the last answer after the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        idx      <= '0;
                        sum_q    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIB; n++) begin
                        if (idx == IDXW'(n)) begin
                            sum_q[4*n +: 4] <= nib_s;
                        end
                    end
                    carry_q <= nib_c;
                    if (idx == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum       <= sum_fin;
                        cout      <= nib_c;
                        ovf       <= ovf_fin;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_add_ctrl.sv
// Directed bench for the nibble-serial adder: a 16-bit instance for the main
// sequences and a 4-bit instance for the single-nibble case.
`timescale 1ns/1ps
module tb_cla_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, sum16;
    logic        cin16, cout16, ovf16, busy16;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, cout4, ovf4, busy4;

    int total = 0;
    int bad   = 0;

    cla_nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .cout      (cout16),
        .ovf       (ovf16),
        .busy      (busy16)
    );

    cla_nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4),
        .busy      (busy4)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set to the 16-bit instance for the accepting edge,
    // then count edges until out_valid (bounded) and check the latency.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                 input logic c, input string tag);
        int n;
        checkOutput({tag, "_ready_before"}, {31'd0, in_ready16}, 32'd1);
        a16        = av;
        b16        = bv;
        cin16      = c;
        in_valid16 = 1'b1;
        step();
        in_valid16 = 1'b0;
        n = 0;
        while (!out_valid16 && n < 20) begin
            step();
            n++;
        end
        checkOutput({tag, "_latency"}, n, 32'd4);
    endtask

    initial begin
        rst = 1'b1;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        in_valid4  = 1'b0; out_ready4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
        #2;
        checkOutput("rst_in_ready",  {31'd0, in_ready16},  32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid16}, 32'd0);
        checkOutput("rst_busy",      {31'd0, busy16},      32'd0);
        checkOutput("rst_sum",       {16'd0, sum16},       32'd0);
        checkOutput("rst_cout_ovf",  {30'd0, cout16, ovf16}, 32'd0);
        checkOutput("rst_w4_ready",  {31'd0, in_ready4},   32'd1);
        step();
        step();
        #1 rst = 1'b0;
        step();

        // FFFF + 0001: full carry ripple through every nibble.
        $display("[TB] carry ripple");
        out_ready16 = 1'b1;
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, "t1");
        checkOutput("t1_sum",  {16'd0, sum16},  32'h0000);
        checkOutput("t1_cout", {31'd0, cout16}, 32'd1);
        checkOutput("t1_ovf",  {31'd0, ovf16},  32'd0);
        checkOutput("t1_busy_done", {31'd0, busy16}, 32'd1);
        step();
        checkOutput("t1_ready_after", {31'd0, in_ready16},  32'd1);
        checkOutput("t1_valid_after", {31'd0, out_valid16}, 32'd0);
        checkOutput("t1_sum_retained", {16'd0, sum16}, 32'h0000);

        // Signed overflow cases.
        $display("[TB] overflow");
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, "t2a");
        checkOutput("t2a_sum",  {16'd0, sum16},  32'h8000);
        checkOutput("t2a_cout", {31'd0, cout16}, 32'd0);
        checkOutput("t2a_ovf",  {31'd0, ovf16},  32'd1);
        step();
        applyStimulus(16'h8000, 16'h8000, 1'b0, "t2b");
        checkOutput("t2b_sum",  {16'd0, sum16},  32'h0000);
        checkOutput("t2b_cout", {31'd0, cout16}, 32'd1);
        checkOutput("t2b_ovf",  {31'd0, ovf16},  32'd1);
        step();

        // Carry-in into nibble 0.
        $display("[TB] carry in");
        applyStimulus(16'h0000, 16'h0000, 1'b1, "t3a");
        checkOutput("t3a_sum",  {16'd0, sum16},  32'h0001);
        checkOutput("t3a_cout", {31'd0, cout16}, 32'd0);
        step();
        applyStimulus(16'h1234, 16'h4321, 1'b1, "t3b");
        checkOutput("t3b_sum",  {16'd0, sum16},  32'h5556);
        checkOutput("t3b_cout", {31'd0, cout16}, 32'd0);
        checkOutput("t3b_ovf",  {31'd0, ovf16},  32'd0);
        step();

        // Backpressure: result held while new operands are waved at the input.
        $display("[TB] backpressure");
        out_ready16 = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 1'b0, "t4");
        for (int i = 0; i < 3; i++) begin
            in_valid16 = 1'b1;
            a16 = 16'hFFFF;
            b16 = 16'hFFFF;
            cin16 = 1'b0;
            step();
            checkOutput("t4_hold_sum",   {16'd0, sum16},       32'h3333);
            checkOutput("t4_hold_flags", {30'd0, cout16, ovf16}, 32'd0);
            checkOutput("t4_hold_valid", {31'd0, out_valid16}, 32'd1);
            checkOutput("t4_hold_ready", {31'd0, in_ready16},  32'd0);
            in_valid16 = (i % 2 == 0) ? 1'b0 : 1'b1;
        end
        in_valid16  = 1'b1;
        out_ready16 = 1'b1;
        step();
        checkOutput("t4_idle_ready", {31'd0, in_ready16},  32'd1);
        checkOutput("t4_idle_valid", {31'd0, out_valid16}, 32'd0);
        checkOutput("t4_idle_busy",  {31'd0, busy16},      32'd0);
        checkOutput("t4_idle_sum",   {16'd0, sum16},       32'h3333);
        step();
        checkOutput("t4_accept_ready", {31'd0, in_ready16}, 32'd0);
        checkOutput("t4_accept_busy",  {31'd0, busy16},     32'd1);
        in_valid16 = 1'b0;
        step();
        step();
        step();
        checkOutput("t4_not_yet", {31'd0, out_valid16}, 32'd0);
        step();
        checkOutput("t4b_valid", {31'd0, out_valid16}, 32'd1);
        checkOutput("t4b_sum",   {16'd0, sum16},       32'hFFFE);
        checkOutput("t4b_cout",  {31'd0, cout16},      32'd1);
        checkOutput("t4b_ovf",   {31'd0, ovf16},       32'd0);
        step();

        // Asynchronous reset in the middle of RUN, with idx at 2.
        $display("[TB] async reset");
        a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; in_valid16 = 1'b1;
        step();
        in_valid16 = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_valid", {31'd0, out_valid16}, 32'd0);
        checkOutput("t5_busy",  {31'd0, busy16},      32'd0);
        checkOutput("t5_ready", {31'd0, in_ready16},  32'd1);
        checkOutput("t5_sum",   {16'd0, sum16},       32'd0);
        #2 rst = 1'b0;
        step();
        applyStimulus(16'h00FF, 16'h0001, 1'b0, "t5b");
        checkOutput("t5b_sum",  {16'd0, sum16},  32'h0100);
        checkOutput("t5b_cout", {31'd0, cout16}, 32'd0);
        step();

        // Single-nibble instance.
        $display("[TB] width 4");
        out_ready4 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b0; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        checkOutput("t6_run_valid", {31'd0, out_valid4}, 32'd0);
        checkOutput("t6_run_busy",  {31'd0, busy4},      32'd1);
        step();
        checkOutput("t6_valid", {31'd0, out_valid4}, 32'd1);
        checkOutput("t6_sum",   {28'd0, sum4},       32'hE);
        checkOutput("t6_cout",  {31'd0, cout4},      32'd1);
        checkOutput("t6_ovf",   {31'd0, ovf4},       32'd0);
        step();
        checkOutput("t6_ready_after", {31'd0, in_ready4}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
